// File: rtl/issue_ctrl_if.sv
// Decoder / issue-slot / writeback bundle for issue_ctrl.
// master: decoder + execute + writeback side (drives dec_*, iss_ready, wb_*, mem_done, flush)
// slave : issue_ctrl (drives dec_ready, iss_*, hazard, inflight)
interface issue_ctrl_if #(
    parameter int unsigned PAYLOAD_W    = 54,
    parameter int unsigned MAX_INFLIGHT = 4
);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic                 dec_valid;
    logic                 dec_ready;
    logic [4:0]           dec_rd;
    logic [4:0]           dec_rs1;
    logic [4:0]           dec_rs2;
    logic                 dec_regwrite;
    logic                 dec_mem;
    logic [PAYLOAD_W-1:0] dec_payload;
    logic                 flush;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [4:0]           iss_rd;
    logic [4:0]           iss_rs1;
    logic [4:0]           iss_rs2;
    logic [PAYLOAD_W-1:0] iss_payload;
    logic                 wb_valid;
    logic [4:0]           wb_rd;
    logic                 mem_done;
    logic                 hazard;
    logic [CNT_W-1:0]     inflight;

    modport master (
        output dec_valid, dec_rd, dec_rs1, dec_rs2, dec_regwrite, dec_mem, dec_payload,
        output flush, iss_ready, wb_valid, wb_rd, mem_done,
        input  dec_ready, iss_valid, iss_rd, iss_rs1, iss_rs2, iss_payload, hazard, inflight
    );

    modport slave (
        input  dec_valid, dec_rd, dec_rs1, dec_rs2, dec_regwrite, dec_mem, dec_payload,
        input  flush, iss_ready, wb_valid, wb_rd, mem_done,
        output dec_ready, iss_valid, iss_rd, iss_rs1, iss_rs2, iss_payload, hazard, inflight
    );
endinterface

// File: rtl/issue_ctrl.sv
// Single-issue in-order issue controller: registered issue slot, 32-entry
// pending-write scoreboard, in-flight regwrite counter and one-deep memory-op lock.
// Ports: clk, rst (sync active-high), bus (issue_ctrl_if.slave).
// Optional: define ISSUE_WB_BYPASS_EN to let a same-cycle writeback unblock
// the hazard and in-flight-full checks (needs write-before-read regfile).
module issue_ctrl #(
    parameter int unsigned PAYLOAD_W    = 54,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic         clk,
    input  logic         rst,
    issue_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic                 iss_valid_q;
    logic [4:0]           iss_rd_q;
    logic [4:0]           iss_rs1_q;
    logic [4:0]           iss_rs2_q;
    logic [PAYLOAD_W-1:0] iss_payload_q;
    logic [31:0]          busy_q;
    logic [CNT_W-1:0]     inflight_q;
    logic                 mem_busy_q;

    logic [31:0]          wb_mask;
    logic                 wb_dec;
    logic [31:0]          busy_eff;
    logic [CNT_W-1:0]     inflight_eff;
    logic                 hazard;
    logic                 dec_ready;
    logic                 issue;
    logic [31:0]          busy_nxt;
    logic [CNT_W-1:0]     inflight_nxt;
    logic                 mem_busy_nxt;

    // Hazard / ready evaluation, optionally looking through this cycle's writeback
    always_comb begin
        wb_mask = bus.wb_valid ? (32'(1) << bus.wb_rd) : 32'd0;
        wb_dec  = bus.wb_valid && (inflight_q != '0);
`ifdef ISSUE_WB_BYPASS_EN
        busy_eff     = busy_q & ~wb_mask;
        inflight_eff = inflight_q - CNT_W'(wb_dec);
`else
        busy_eff     = busy_q;
        inflight_eff = inflight_q;
`endif
        hazard = bus.dec_valid & (busy_eff[bus.dec_rs1] | busy_eff[bus.dec_rs2]
                                  | (bus.dec_regwrite & busy_eff[bus.dec_rd]));
        dec_ready = (!iss_valid_q || bus.iss_ready) && !hazard && !bus.flush
                    && !(bus.dec_regwrite && (inflight_eff == CNT_W'(MAX_INFLIGHT)))
                    && !(bus.dec_mem && mem_busy_q);
        issue = bus.dec_valid && dec_ready;
    end

    // Scoreboard / counter / memory-lock next state; a same-cycle set beats a clear
    always_comb begin
        busy_nxt = busy_q & ~wb_mask;
        if (issue && bus.dec_regwrite && (bus.dec_rd != 5'd0)) begin
            busy_nxt[bus.dec_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;

        inflight_nxt = inflight_q + CNT_W'(issue && bus.dec_regwrite) - CNT_W'(wb_dec);

        mem_busy_nxt = mem_busy_q && !bus.mem_done;
        if (issue && bus.dec_mem) begin
            mem_busy_nxt = 1'b1;
        end
    end

    // Issue slot and tracking state; flush kills the slot even when execute is ready
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q   <= 1'b0;
            iss_rd_q      <= 5'd0;
            iss_rs1_q     <= 5'd0;
            iss_rs2_q     <= 5'd0;
            iss_payload_q <= '0;
            busy_q        <= 32'd0;
            inflight_q    <= '0;
            mem_busy_q    <= 1'b0;
        end else begin
            if (bus.flush) begin
                iss_valid_q <= 1'b0;
            end else if (issue) begin
                iss_valid_q   <= 1'b1;
                iss_rd_q      <= bus.dec_rd;
                iss_rs1_q     <= bus.dec_rs1;
                iss_rs2_q     <= bus.dec_rs2;
                iss_payload_q <= bus.dec_payload;
            end else if (bus.iss_ready) begin
                iss_valid_q <= 1'b0;
            end
            busy_q     <= busy_nxt;
            inflight_q <= inflight_nxt;
            mem_busy_q <= mem_busy_nxt;
        end
    end

    assign bus.dec_ready   = dec_ready;
    assign bus.hazard      = hazard;
    assign bus.iss_valid   = iss_valid_q;
    assign bus.iss_rd      = iss_rd_q;
    assign bus.iss_rs1     = iss_rs1_q;
    assign bus.iss_rs2     = iss_rs2_q;
    assign bus.iss_payload = iss_payload_q;
    assign bus.inflight    = inflight_q;
endmodule
